tft_pic_gen: RTL and testbench

Pixel source feeding the TFT timing driver's 16-bit data input. It tracks raster position from the driver's tft_de strobe and outputs one RGB565 word per active pixel. The picture is 8 vertical colour bars with a 100x100 sprite overlaid; the sprite is read from an external synchronous image ROM. The sprite bounces around the 800x480 panel, moving once per frame during vertical blanking.

---
 rtl/tft_pic_gen.sv | 148 ++++++++++++++
 tb/tb_tft_pic_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_pic_gen.sv
// Pixel source for the TFT driver: eight colour bars with a bouncing sprite
// read from a 1-cycle-latency image ROM, raster position recovered from tft_de.
module tft_pic_gen #(
    parameter int H_DISP = 800,
    parameter int V_DISP = 480,
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int STEP   = 4,
    parameter int BAR_W  = H_DISP / 8
) (
    input  logic        clk_33_3m,
    input  logic        rst_n,
    input  logic        tft_de,
    input  logic [1:0]  mode,
    input  logic        move_en,
    output logic [13:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] data_out,
    output logic        frame_end,
    output logic [10:0] sprite_x,
    output logic [10:0] sprite_y
);

    localparam logic [10:0] Y_LAST = 11'(V_DISP - 1);
    localparam logic [10:0] X_MAX  = 11'(H_DISP - IMG_W);
    localparam logic [10:0] Y_MAX  = 11'(V_DISP - IMG_H);
    localparam logic [10:0] STEP_W = 11'(STEP);

    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic        de_q;
    logic        dir_x;     // 0 = moving right/down, 1 = moving left/up
    logic        dir_y;
    logic        in_sprite_q;
    logic [15:0] bar_q;

    logic [10:0] nx;
    logic [10:0] ny;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] bar_idx;
    logic        hit;
    logic        de_fall;
    logic [15:0] bar_colour;

    // Coordinate the driver samples next cycle, so the ROM word lines up with it.
    always_comb begin
        nx      = tft_de ? (x_cnt + 11'd1) : 11'd0;
        ny      = y_cnt;
        dx      = nx - sprite_x;
        dy      = ny - sprite_y;
        hit     = (dx < 11'(IMG_W)) && (dy < 11'(IMG_H));
        de_fall = de_q && !tft_de;
        bar_idx = nx / 11'(BAR_W);
    end

    always_comb begin
        rom_addr = '0;
        if (hit) begin
            rom_addr = 14'(dy) * 14'(IMG_W) + 14'(dx);
        end
    end

    always_comb begin
        bar_colour = 16'h0000;
        case (bar_idx)
            11'd0:   bar_colour = 16'hFFFF;
            11'd1:   bar_colour = 16'hFFE0;
            11'd2:   bar_colour = 16'h07FF;
            11'd3:   bar_colour = 16'h07E0;
            11'd4:   bar_colour = 16'hF81F;
            11'd5:   bar_colour = 16'hF800;
            11'd6:   bar_colour = 16'h001F;
            default: bar_colour = 16'h0000;
        endcase
    end

    always_comb begin
        data_out = 16'h0000;
        if (tft_de) begin
            case (mode)
                2'd0:    data_out = in_sprite_q ? rom_data : bar_q;
                2'd1:    data_out = bar_q;
                2'd2:    data_out = in_sprite_q ? rom_data : 16'h0000;
                default: data_out = 16'hFFFF;
            endcase
        end
    end

    always_ff @(posedge clk_33_3m or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            de_q        <= 1'b0;
            frame_end   <= 1'b0;
            in_sprite_q <= 1'b0;
            bar_q       <= '0;
        end else begin
            de_q        <= tft_de;
            x_cnt       <= tft_de ? (x_cnt + 11'd1) : 11'd0;
            frame_end   <= de_fall && (y_cnt == Y_LAST);
            in_sprite_q <= hit;
            bar_q       <= bar_colour;
            if (de_fall) begin
                y_cnt <= (y_cnt == Y_LAST) ? 11'd0 : (y_cnt + 11'd1);
            end
        end
    end

    // Motion only on the frame_end cycle, which lies in vertical blanking.
    always_ff @(posedge clk_33_3m or negedge rst_n) begin
        if (!rst_n) begin
            sprite_x <= '0;
            sprite_y <= '0;
            dir_x    <= 1'b0;
            dir_y    <= 1'b0;
        end else if (frame_end && move_en) begin
            if (!dir_x) begin
                if (sprite_x + STEP_W > X_MAX) begin
                    sprite_x <= X_MAX;
                    dir_x    <= 1'b1;
                end else begin
                    sprite_x <= sprite_x + STEP_W;
                end
            end else if (sprite_x < STEP_W) begin
                sprite_x <= '0;
                dir_x    <= 1'b0;
            end else begin
                sprite_x <= sprite_x - STEP_W;
            end

            if (!dir_y) begin
                if (sprite_y + STEP_W > Y_MAX) begin
                    sprite_y <= Y_MAX;
                    dir_y    <= 1'b1;
                end else begin
                    sprite_y <= sprite_y + STEP_W;
                end
            end else if (sprite_y < STEP_W) begin
                sprite_y <= '0;
                dir_y    <= 1'b0;
            end else begin
                sprite_y <= sprite_y - STEP_W;
            end
        end
    end

endmodule

// File: tb/tb_tft_pic_gen.sv
// Directed bench for tft_pic_gen: full-size instance for picture content and
// reset, short-frame instance for bounce and frame_end behaviour.
module tb_tft_pic_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de = 1'b0;
    logic [1:0]  mode = 2'd1;
    logic        move_en = 1'b0;
    logic [15:0] rom_data = 16'h0000;
    logic [13:0] rom_addr;
    logic [15:0] data_out;
    logic        frame_end;
    logic [10:0] sprite_x, sprite_y;

    logic        de_b = 1'b0;
    logic [1:0]  mode_b = 2'd0;
    logic        move_en_b = 1'b0;
    logic [15:0] rom_data_b = 16'h0000;
    logic [13:0] rom_addr_b;
    logic [15:0] data_out_b;
    logic        frame_end_b;
    logic [10:0] sprite_x_b, sprite_y_b;

    int total = 0;
    int fails = 0;
    int fe = 0;
    int fe_b = 0;
    int bad_frames = 0;
    int bad_moves = 0;
    logic [10:0] px_prev, py_prev;
    logic        fe_prev;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [15:0] exp;

    tft_pic_gen u_dut (
        .clk_33_3m (clk),
        .rst_n     (rst_n),
        .tft_de    (de),
        .mode      (mode),
        .move_en   (move_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .data_out  (data_out),
        .frame_end (frame_end),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y)
    );

    tft_pic_gen #(.V_DISP(108)) u_dut_b (
        .clk_33_3m (clk),
        .rst_n     (rst_n),
        .tft_de    (de_b),
        .mode      (mode_b),
        .move_en   (move_en_b),
        .rom_addr  (rom_addr_b),
        .rom_data  (rom_data_b),
        .data_out  (data_out_b),
        .frame_end (frame_end_b),
        .sprite_x  (sprite_x_b),
        .sprite_y  (sprite_y_b)
    );

    always #15 clk = ~clk;

    // Image ROM stand-in: word equals its address, one cycle late.
    always @(posedge clk) rom_data <= {2'b00, rom_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic d);
        @(negedge clk);
        de = d;
        #1;
        if (frame_end) fe++;
    endtask

    task automatic tick_b(input logic d);
        @(negedge clk);
        de_b = d;
        #1;
        if ((sprite_x_b !== px_prev || sprite_y_b !== py_prev) && !fe_prev) bad_moves++;
        px_prev = sprite_x_b;
        py_prev = sprite_y_b;
        fe_prev = frame_end_b;
        if (frame_end_b) fe_b++;
    endtask

    task automatic frame_b(input int toggle_line);
        fe_b = 0;
        for (int l = 0; l < 108; l++) begin
            if (l == toggle_line) move_en_b = 1'b1;
            tick_b(1'b1);
            tick_b(1'b0);
        end
        tick_b(1'b0);
        tick_b(1'b0);
        if (fe_b != 1) bad_frames++;
    endtask

    initial begin
        // Reset state
        repeat (3) tick(1'b0);
        chk("rst_data_out", data_out, 16'h0000);
        chk("rst_frame_end", frame_end, 1'b0);
        chk("rst_sprite_x", sprite_x, 11'd0);
        chk("rst_sprite_y", sprite_y, 11'd0);
        chk("rst_rom_addr", rom_addr, 14'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick(1'b0);

        // Row 0, bars only
        mode = 2'd1;
        for (int p = 0; p < 800; p++) begin
            tick(1'b1);
            chk("bars_r0", data_out, bars[p / 100]);
        end
        tick(1'b0);
        chk("de_low_zero", data_out, 16'h0000);
        repeat (255) tick(1'b0);

        // Rest of frame on short lines; exactly one frame_end pulse expected
        fe = 0;
        for (int r = 1; r < 480; r++) begin
            tick(1'b1);
            tick(1'b0);
        end
        repeat (4) tick(1'b0);
        chk("frame_end_pulses", fe, 1);
        chk("frozen_sprite_x", sprite_x, 11'd0);

        // Row 0, bars + sprite at (0,0)
        mode = 2'd0;
        chk("lookahead_addr_r0", rom_addr, 14'd0);
        for (int p = 0; p < 800; p++) begin
            tick(1'b1);
            exp = (p < 100) ? 16'(p) : bars[p / 100];
            chk("sprite_r0", data_out, exp);
        end
        repeat (8) tick(1'b0);
        for (int r = 1; r < 99; r++) begin
            tick(1'b1);
            tick(1'b0);
        end
        repeat (3) tick(1'b0);
        chk("lookahead_addr_r99", rom_addr, 14'd9900);

        // Row 99: mode 0 then mode 2 mid-sprite
        for (int p = 0; p < 800; p++) begin
            mode = (p < 50) ? 2'd0 : 2'd2;
            tick(1'b1);
            exp = (p < 100) ? 16'(9900 + p) : 16'h0000;
            chk("sprite_r99", data_out, exp);
        end
        repeat (8) tick(1'b0);
        chk("addr_outside_r100", rom_addr, 14'd0);

        // Row 100: all four modes across the line
        for (int p = 0; p < 800; p++) begin
            mode = (p < 200) ? 2'd0 : (p < 400) ? 2'd1 : (p < 600) ? 2'd2 : 2'd3;
            tick(1'b1);
            exp = (p < 400) ? bars[p / 100] : (p < 600) ? 16'h0000 : 16'hFFFF;
            chk("modes_r100", data_out, exp);
        end
        repeat (8) tick(1'b0);

        // One moving frame on the full-size instance
        move_en = 1'b1;
        fe = 0;
        for (int r = 101; r < 480; r++) begin
            tick(1'b1);
            tick(1'b0);
        end
        repeat (4) tick(1'b0);
        move_en = 1'b0;
        chk("move_frame_pulses", fe, 1);
        chk("moved_sprite_x", sprite_x, 11'd4);
        chk("moved_sprite_y", sprite_y, 11'd4);

        // Reset in the middle of row 1 at x=400
        mode = 2'd0;
        tick(1'b1);
        tick(1'b0);
        repeat (3) tick(1'b0);
        for (int p = 0; p < 400; p++) tick(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        de = 1'b0;
        repeat (2) tick(1'b0);
        chk("midrst_data_out", data_out, 16'h0000);
        chk("midrst_frame_end", frame_end, 1'b0);
        chk("midrst_sprite_x", sprite_x, 11'd0);
        chk("midrst_sprite_y", sprite_y, 11'd0);
        chk("midrst_rom_addr", rom_addr, 14'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick(1'b0);
        for (int p = 0; p < 800; p++) begin
            mode = (p < 100) ? 2'd0 : 2'd3;
            tick(1'b1);
            exp = (p < 100) ? 16'(p) : 16'hFFFF;
            chk("after_rst_row0", data_out, exp);
        end
        repeat (4) tick(1'b0);

        // Bounce on the short-frame instance (X limit 700, Y limit 8)
        px_prev = sprite_x_b;
        py_prev = sprite_y_b;
        fe_prev = 1'b0;
        move_en_b = 1'b1;
        for (int n = 1; n <= 177; n++) begin
            frame_b(-1);
            if (n == 2)   chk("y_after_2", sprite_y_b, 11'd8);
            if (n == 3)   chk("y_after_3", sprite_y_b, 11'd8);
            if (n == 4)   chk("y_after_4", sprite_y_b, 11'd4);
            if (n == 175) chk("x_after_175", sprite_x_b, 11'd700);
            if (n == 176) chk("x_after_176", sprite_x_b, 11'd700);
            if (n == 177) chk("x_after_177", sprite_x_b, 11'd696);
        end
        chk("bad_frames", bad_frames, 0);

        // Frozen for 10 frames, then enabled mid-frame
        move_en_b = 1'b0;
        for (int n = 0; n < 10; n++) frame_b(-1);
        chk("frozen_x_b", sprite_x_b, 11'd696);
        chk("frozen_y_b", sprite_y_b, 11'd8);
        frame_b(54);
        chk("resume_x_b", sprite_x_b, 11'd692);
        chk("resume_y_b", sprite_y_b, 11'd4);
        chk("bad_frames_all", bad_frames, 0);
        chk("moves_off_frame_end", bad_moves, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
